// File: rtl/fpga_robots_game_tmarb_pkg.sv
// fpga_robots_game_tmarb_pkg: shared widths, requester ids and helpers for the tile map arbiter
package fpga_robots_game_tmarb_pkg;

    localparam int TM_ADR_W = 13;
    localparam int TM_DAT_W = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    function automatic req_id_t other(input req_id_t id);
        return id == REQ_A ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/fpga_robots_game_tmarb_if.sv
// fpga_robots_game_tmarb_if: one requester's access port into the tile map arbiter
interface fpga_robots_game_tmarb_if #(
    parameter int ADR_W = 13,
    parameter int DAT_W = 8
);
    logic             req;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] wrt;
    logic             wen;
    logic             gnt;
    logic [DAT_W-1:0] red;
    logic             rvld;

    modport master (output req, adr, wrt, wen, input gnt, red, rvld);
    modport slave  (input req, adr, wrt, wen, output gnt, red, rvld);
endinterface

// File: rtl/fpga_robots_game_tmarb_rdpipe.sv
// fpga_robots_game_tmarb_rdpipe: read tag pipeline matching memory latency, routes returned data to its requester
module fpga_robots_game_tmarb_rdpipe
    import fpga_robots_game_tmarb_pkg::*;
#(
    parameter int DAT_W  = TM_DAT_W,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  req_id_t          id,
    input  logic [DAT_W-1:0] tm_red,
    output logic             a_rvld,
    output logic             b_rvld,
    output logic [DAT_W-1:0] a_red,
    output logic [DAT_W-1:0] b_red
);
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] idb;
    logic              ret_a;
    logic              ret_b;

    always_comb begin
        ret_a = vld[RD_LAT-1] && !idb[RD_LAT-1];
        ret_b = vld[RD_LAT-1] && idb[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            idb    <= '0;
            a_rvld <= 1'b0;
            b_rvld <= 1'b0;
            a_red  <= '0;
            b_red  <= '0;
        end else begin
            vld    <= RD_LAT'({vld, issue});
            idb    <= RD_LAT'({idb, id == REQ_B});
            a_rvld <= ret_a;
            b_rvld <= ret_b;
            if (ret_a) a_red <= tm_red;
            if (ret_b) b_red <= tm_red;
        end
    end
endmodule

// File: rtl/fpga_robots_game_tmarb.sv
// fpga_robots_game_tmarb: shares the video tile map port between game logic (A) and the debug agent (B)
module fpga_robots_game_tmarb
    import fpga_robots_game_tmarb_pkg::*;
#(
    parameter int ADR_W      = TM_ADR_W,
    parameter int DAT_W      = TM_DAT_W,
    parameter int RD_LAT     = 1,
    parameter int MAX_HOLD   = 8,
    parameter bit B_VBI_ONLY = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vbi,
    fpga_robots_game_tmarb_if.slave a,
    fpga_robots_game_tmarb_if.slave b,
    output logic [ADR_W-1:0]        tm_adr,
    output logic [DAT_W-1:0]        tm_wrt,
    output logic                    tm_wen,
    input  logic [DAT_W-1:0]        tm_red,
    output logic                    busy_b
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    req_id_t          lo;
    req_id_t          win;
    logic [HW-1:0]    hc;
    logic             eb;
    logic             any;
    logic             keep;
    logic             win_b;
    logic             a_rvld;
    logic             b_rvld;
    logic [DAT_W-1:0] a_red;
    logic [DAT_W-1:0] b_red;

    // a burst continues only while the last owner was granted in the cycle just gone
    always_comb begin
        eb    = b.req && (!B_VBI_ONLY || vbi);
        any   = a.req || eb;
        keep  = hc < HW'(MAX_HOLD) && (lo == REQ_B ? b.gnt : a.gnt);
        win   = (a.req && eb) ? (keep ? lo : other(lo)) : (eb ? REQ_B : REQ_A);
        win_b = win == REQ_B;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a.gnt  <= 1'b0;
            b.gnt  <= 1'b0;
            tm_adr <= '0;
            tm_wrt <= '0;
            tm_wen <= 1'b0;
            lo     <= REQ_B;
            hc     <= '0;
        end else begin
            a.gnt  <= any && !win_b;
            b.gnt  <= any && win_b;
            tm_wen <= any && (win_b ? b.wen : a.wen);
            if (any) begin
                tm_adr <= win_b ? b.adr : a.adr;
                tm_wrt <= win_b ? b.wrt : a.wrt;
                lo     <= win;
                hc     <= win != lo ? HW'(1) : hc == HW'(MAX_HOLD) ? hc : hc + 1'b1;
            end
        end
    end

    assign busy_b = lo == REQ_B && hc != '0;

    fpga_robots_game_tmarb_rdpipe #(
        .DAT_W  (DAT_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk    (clk),
        .rst    (rst),
        .issue  ((a.gnt || b.gnt) && !tm_wen),
        .id     (b.gnt ? REQ_B : REQ_A),
        .tm_red (tm_red),
        .a_rvld (a_rvld),
        .b_rvld (b_rvld),
        .a_red  (a_red),
        .b_red  (b_red)
    );

    assign a.rvld = a_rvld;
    assign b.rvld = b_rvld;
    assign a.red  = a_red;
    assign b.red  = b_red;

    assert property (@(posedge clk) disable iff (rst) !(a.gnt && b.gnt));
endmodule

// File: tb/tb_fpga_robots_game_tmarb.sv
// tb_fpga_robots_game_tmarb: directed and random stimulus against a cycle-level reference of the tile map arbiter
module tb_fpga_robots_game_tmarb;
    localparam int ADR_W    = 13;
    localparam int DAT_W    = 8;
    localparam int MAX_HOLD = 8;
    localparam bit VBI_ONLY = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vbi = 1'b0;
    always #5 clk = ~clk;

    fpga_robots_game_tmarb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) a_if ();
    fpga_robots_game_tmarb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) b_if ();

    logic [ADR_W-1:0] tm_adr;
    logic [DAT_W-1:0] tm_wrt;
    logic [DAT_W-1:0] tm_red;
    logic             tm_wen;
    logic             busy_b;

    fpga_robots_game_tmarb #(
        .ADR_W      (ADR_W),
        .DAT_W      (DAT_W),
        .RD_LAT     (1),
        .MAX_HOLD   (MAX_HOLD),
        .B_VBI_ONLY (VBI_ONLY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vbi    (vbi),
        .a      (a_if),
        .b      (b_if),
        .tm_adr (tm_adr),
        .tm_wrt (tm_wrt),
        .tm_wen (tm_wen),
        .tm_red (tm_red),
        .busy_b (busy_b)
    );

    logic [DAT_W-1:0] mem [2**ADR_W];
    always @(posedge clk) begin
        if (tm_wen) mem[tm_adr] <= tm_wrt;
        tm_red <= mem[tm_adr];
    end

    typedef struct {
        int             due;
        int             id;
        logic [DAT_W-1:0] d;
    } rd_t;

    logic [DAT_W-1:0] ref_mem [2**ADR_W];
    rd_t              pend[$];
    int               m_owner = 1;
    int               m_streak = 0;
    int               m_prev = -1;
    int               cyc = 0;
    logic             e_agnt, e_bgnt, e_wen, e_arvld, e_brvld, e_busy;
    logic [ADR_W-1:0] e_adr;
    logic [DAT_W-1:0] e_wrt, e_ared, e_bred;
    int               checks = 0;
    int               errors = 0;
    int               na_gnt, nb_gnt, na_rvld, nb_rvld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic setab(input logic ar, input logic [ADR_W-1:0] aa, input logic [DAT_W-1:0] aw, input logic ae,
                         input logic br, input logic [ADR_W-1:0] ba, input logic [DAT_W-1:0] bw, input logic be);
        a_if.req = ar; a_if.adr = aa; a_if.wrt = aw; a_if.wen = ae;
        b_if.req = br; b_if.adr = ba; b_if.wrt = bw; b_if.wen = be;
    endtask

    task automatic clear_counts();
        na_gnt = 0; nb_gnt = 0; na_rvld = 0; nb_rvld = 0;
    endtask

    // predict the outcome of the coming edge from the arbitration rules, then compare after it
    task automatic step();
        int               win;
        rd_t              r;
        logic             ea, eb, wen;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] wrt;
        cyc++;
        e_agnt = 0; e_bgnt = 0; e_wen = 0; e_arvld = 0; e_brvld = 0;
        if (rst) begin
            pend.delete();
            m_owner = 1; m_streak = 0; m_prev = -1;
            e_adr = '0; e_wrt = '0; e_ared = '0; e_bred = '0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (r.id == 0) begin e_arvld = 1; e_ared = r.d; end
                else begin e_brvld = 1; e_bred = r.d; end
            end
            ea = a_if.req;
            eb = b_if.req && (!VBI_ONLY || vbi);
            if (ea && eb) win = (m_prev == m_owner && m_streak < MAX_HOLD) ? m_owner : 1 - m_owner;
            else win = ea ? 0 : eb ? 1 : -1;
            if (win >= 0) begin
                adr = win == 1 ? b_if.adr : a_if.adr;
                wrt = win == 1 ? b_if.wrt : a_if.wrt;
                wen = win == 1 ? b_if.wen : a_if.wen;
                e_agnt = win == 0; e_bgnt = win == 1;
                e_wen = wen; e_adr = adr; e_wrt = wrt;
                if (wen) ref_mem[adr] = wrt;
                else begin
                    r.due = cyc + 2; r.id = win; r.d = ref_mem[adr];
                    pend.push_back(r);
                end
                m_streak = (win == m_owner) ? (m_streak < MAX_HOLD ? m_streak + 1 : MAX_HOLD) : 1;
                m_owner = win;
            end
            m_prev = win;
        end
        e_busy = m_owner == 1 && m_streak > 0;
        @(posedge clk);
        #1;
        check("a_gnt", a_if.gnt, e_agnt);
        check("b_gnt", b_if.gnt, e_bgnt);
        check("tm_wen", tm_wen, e_wen);
        check("tm_adr", tm_adr, e_adr);
        check("tm_wrt", tm_wrt, e_wrt);
        check("a_rvld", a_if.rvld, e_arvld);
        check("b_rvld", b_if.rvld, e_brvld);
        check("a_red", a_if.red, e_ared);
        check("b_red", b_if.red, e_bred);
        check("busy_b", busy_b, e_busy);
        na_gnt += int'(a_if.gnt); nb_gnt += int'(b_if.gnt);
        na_rvld += int'(a_if.rvld); nb_rvld += int'(b_if.rvld);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**ADR_W; i++) begin
            mem[i] = DAT_W'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[i] = DAT_W'(8'h10 + i);
            ref_mem[i] = mem[i];
        end
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        clear_counts();
        for (int i = 0; i < 4; i++) begin
            setab(1, ADR_W'(i), 0, 0, 0, 0, 0, 0);
            step();
        end
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        check("a_only_gnt_cnt", na_gnt, 4);
        check("a_only_rvld_cnt", na_rvld, 4);
        check("a_only_b_rvld_cnt", nb_rvld, 0);
        check("a_only_last_red", a_if.red, 8'h13);

        do_reset();
        vbi = 1'b1;
        clear_counts();
        setab(1, 13'h0010, 0, 0, 1, 13'h0020, 0, 0);
        step();
        check("first_winner_a", a_if.gnt, 1);
        repeat (31) step();
        check("alt_a_cnt", na_gnt, 16);
        check("alt_b_cnt", nb_gnt, 16);
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        do_reset();
        vbi = 1'b0;
        clear_counts();
        setab(0, 0, 0, 0, 1, 13'h0033, 0, 0);
        repeat (20) step();
        check("vbi_block_b_cnt", nb_gnt, 0);
        vbi = 1'b1;
        step();
        check("vbi_rise_b_gnt", b_if.gnt, 1);
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        clear_counts();
        setab(0, 0, 0, 0, 1, 13'h1ABC, 8'h5A, 1);
        step();
        check("bw_tm_wen", tm_wen, 1);
        check("bw_tm_adr", tm_adr, 13'h1ABC);
        check("bw_tm_wrt", tm_wrt, 8'h5A);
        setab(1, 13'h1ABC, 0, 0, 0, 0, 0, 0);
        step();
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("raw_a_red", a_if.red, 8'h5A);
        check("raw_b_rvld_cnt", nb_rvld, 0);

        clear_counts();
        setab(1, 13'h0002, 0, 0, 0, 0, 0, 0);
        step();
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (3) step();
        check("rst_flush_rvld_cnt", na_rvld, 0);

        setab(1, 13'h0005, 8'h77, 1, 0, 0, 0, 0);
        #2;
        a_if.req = 1'b0;
        step();
        check("drop_no_gnt", a_if.gnt, 0);
        check("drop_no_wen", tm_wen, 0);

        for (int n = 0; n < 3000; n++) begin
            setab($urandom_range(3) != 0, ADR_W'($urandom_range(7)), DAT_W'($urandom), 1'($urandom),
                  $urandom_range(3) != 0, ADR_W'($urandom_range(7)), DAT_W'($urandom), 1'($urandom));
            rst = $urandom_range(99) == 0;
            if ($urandom_range(15) == 0) vbi = ~vbi;
            step();
        end
        rst = 1'b0;
        setab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
